// File: rtl/inert_intf.sv
// Inertial sensor command sequencer: configures the sensor over the SPI monarch
// after a power-up delay, then reads the yaw rate on every data-ready interrupt.
module inert_intf #(
  parameter int DLY_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] inert_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  localparam logic [15:0] CMD_INT1  = 16'h0D02;
  localparam logic [15:0] CMD_ODR   = 16'h1160;
  localparam logic [15:0] CMD_ROUND = 16'h1440;
  localparam logic [15:0] CMD_YAWL  = 16'hA600;
  localparam logic [15:0] CMD_YAWH  = 16'hA700;
  localparam logic [DLY_W-1:0] TMR_ONE = 1;

  typedef enum logic [2:0] {
    PWRUP, CFG1, CFG2, CFG3, WAIT_INT, RD_L, RD_H
  } state_t;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  tmr_q, tmr_d;
  logic              int_ff1_q, int_ff2_q;
  logic              wrt_q, wrt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [7:0]        yawl_q, yawl_d;
  logic [15:0]       yaw_q, yaw_d;
  logic              vld_q, vld_d;
  logic              done_ok;

  // done may still be high from the previous transaction during the wrt cycle;
  // the monarch clears it on that edge, so only later cycles count.
  assign done_ok = done & ~wrt_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    yawl_d  = yawl_q;
    yaw_d   = yaw_q;
    vld_d   = 1'b0;
    unique case (state_q)
      PWRUP: begin
        tmr_d = tmr_q + TMR_ONE;
        if (&tmr_q) begin
          wrt_d   = 1'b1;
          cmd_d   = CMD_INT1;
          state_d = CFG1;
        end
      end
      CFG1: if (done_ok) begin
        wrt_d   = 1'b1;
        cmd_d   = CMD_ODR;
        state_d = CFG2;
      end
      CFG2: if (done_ok) begin
        wrt_d   = 1'b1;
        cmd_d   = CMD_ROUND;
        state_d = CFG3;
      end
      CFG3: if (done_ok) state_d = WAIT_INT;
      WAIT_INT: if (int_ff2_q) begin
        wrt_d   = 1'b1;
        cmd_d   = CMD_YAWL;
        state_d = RD_L;
      end
      RD_L: if (done_ok) begin
        yawl_d  = inert_data[7:0];
        wrt_d   = 1'b1;
        cmd_d   = CMD_YAWH;
        state_d = RD_H;
      end
      RD_H: if (done_ok) begin
        yaw_d   = {inert_data[7:0], yawl_q};
        vld_d   = 1'b1;
        state_d = WAIT_INT;
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PWRUP;
      tmr_q     <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      yawl_q    <= 8'h00;
      yaw_q     <= 16'h0000;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      yawl_q    <= yawl_d;
      yaw_q     <= yaw_d;
      vld_q     <= vld_d;
    end
  end

  assign wrt    = wrt_q;
  assign cmd    = cmd_q;
  assign yaw_rt = yaw_q;
  assign vld    = vld_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI monarch model with done 40 cycles after each wrt,
// scoreboard queues for expected commands and yaw values.
module tb_inert_intf;

  localparam int DONE_DLY = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] inert_data = 16'h0000;
  logic        wrt, vld;
  logic [15:0] cmd, yaw_rt;

  inert_intf #(.DLY_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .inert_data(inert_data),
    .wrt(wrt), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_cmd[$];
  logic [15:0] exp_yaw[$];
  logic [7:0]  rd_q[$];

  int errors = 0, checks = 0;
  int wrt_cnt = 0, vld_cnt = 0;
  int last_wrt_cyc = 0, done_cyc = 0, rel_cyc = 0;
  int mcnt = 0;
  bit clr_pend = 1'b0;
  bit vld_prev = 1'b0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [15:0] yaw_prev = 16'h0000;

  // Monitor first, then the monarch model, all at the negedge.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [7:0]  hb;
    if (!rst_n) begin
      mcnt = 0; clr_pend = 1'b0; done = 1'b0;
      yaw_prev = 16'h0000; vld_prev = 1'b0;
    end else begin
      checks++;
      if (!vld && yaw_rt !== yaw_prev) begin
        errors++;
        $display("FAIL yaw_hold cyc=%0d got=%h want=%h", cyc, yaw_rt, yaw_prev);
      end
      if (vld) begin
        vld_cnt++;
        checks++;
        if (exp_yaw.size() == 0) begin
          errors++;
          $display("FAIL unexp_vld cyc=%0d yaw=%h", cyc, yaw_rt);
        end else begin
          e = exp_yaw.pop_front();
          if (yaw_rt !== e) begin
            errors++;
            $display("FAIL yaw_val cyc=%0d got=%h want=%h", cyc, yaw_rt, e);
          end
        end
        checks++;
        if (vld_prev) begin
          errors++;
          $display("FAIL vld_double cyc=%0d got=1 want=0", cyc);
        end
      end
      yaw_prev = yaw_rt;
      vld_prev = vld;

      if (wrt) begin
        wrt_cnt++;
        last_wrt_cyc = cyc;
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL unexp_wrt cyc=%0d cmd=%h", cyc, cmd);
        end else begin
          e = exp_cmd.pop_front();
          if (cmd !== e) begin
            errors++;
            $display("FAIL cmd_val cyc=%0d got=%h want=%h", cyc, cmd, e);
          end
        end
        cur_cmd  = cmd;
        mcnt     = DONE_DLY;
        clr_pend = 1'b1;   // done stays high through the wrt cycle's closing edge
      end else begin
        if (clr_pend) begin
          done = 1'b0;
          clr_pend = 1'b0;
        end
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            checks++;
            if (cmd !== cur_cmd) begin
              errors++;
              $display("FAIL cmd_stable cyc=%0d got=%h want=%h", cyc, cmd, cur_cmd);
            end
            hb = 8'($urandom);
            if (cur_cmd[15] && rd_q.size() > 0) inert_data = {hb, rd_q.pop_front()};
            else inert_data = {hb, hb};
            done = 1'b1;
            done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic wait_wrt(input int n);
    int b = 0;
    while (wrt_cnt < n && b < 400) begin
      @(negedge clk); #1;
      b++;
    end
  endtask

  task automatic wait_vld(input int n);
    int b = 0;
    while (vld_cnt < n && b < 400) begin
      @(negedge clk); #1;
      b++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (wrt !== 1'b0)        begin errors++; $display("FAIL rst_wrt got=%b want=0", wrt); end
    if (vld !== 1'b0)        begin errors++; $display("FAIL rst_vld got=%b want=0", vld); end
    if (cmd !== 16'h0000)    begin errors++; $display("FAIL rst_cmd got=%h want=0000", cmd); end
    if (yaw_rt !== 16'h0000) begin errors++; $display("FAIL rst_yaw got=%h want=0000", yaw_rt); end
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_config();
    int base = wrt_cnt;
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1160);
    exp_cmd.push_back(16'h1440);
    wait_wrt(base + 1);
    checks++;
    if (wrt_cnt != base + 1 || last_wrt_cyc != rel_cyc + 16) begin
      errors++;
      $display("FAIL pwrup_dly got=%0d want=%0d", last_wrt_cyc - rel_cyc, 16);
    end
    for (int k = 2; k <= 3; k++) begin
      wait_wrt(base + k);
      checks++;
      if (wrt_cnt != base + k || last_wrt_cyc != done_cyc + 1) begin
        errors++;
        $display("FAIL cfg%0d_lat got=%0d want=1 wrts=%0d", k, last_wrt_cyc - done_cyc, wrt_cnt - base);
      end
    end
    repeat (60) @(negedge clk);
    #1;
    checks++;
    if (wrt_cnt != base + 3) begin
      errors++;
      $display("FAIL idle_no_wrt got=%0d want=%0d", wrt_cnt - base, 3);
    end
  endtask

  task automatic test_read(input logic [7:0] lo, input logic [7:0] hi);
    int base = wrt_cnt;
    int vb = vld_cnt;
    int int_cyc;
    logic [15:0] old = yaw_rt;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    rd_q.push_back(lo);
    rd_q.push_back(hi);
    exp_yaw.push_back({hi, lo});
    @(negedge clk);
    INT = 1'b1;
    int_cyc = cyc;
    wait_wrt(base + 1);
    INT = 1'b0;
    checks++;
    if (wrt_cnt != base + 1 || last_wrt_cyc != int_cyc + 3) begin
      errors++;
      $display("FAIL int_lat got=%0d want=3", last_wrt_cyc - int_cyc);
    end
    wait_wrt(base + 2);
    checks++;
    if (yaw_rt !== old) begin
      errors++;
      $display("FAIL yaw_partial got=%h want=%h", yaw_rt, old);
    end
    wait_vld(vb + 1);
    checks++;
    if (vld_cnt != vb + 1 || yaw_rt !== {hi, lo}) begin
      errors++;
      $display("FAIL read_done got=%h want=%h vlds=%0d", yaw_rt, {hi, lo}, vld_cnt - vb);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wrt_cnt != base + 2) begin
      errors++;
      $display("FAIL read_wrts got=%0d want=2", wrt_cnt - base);
    end
  endtask

  task automatic test_int_during_rdh();
    int base = wrt_cnt;
    int vb = vld_cnt;
    exp_cmd.push_back(16'hA600);
    exp_cmd.push_back(16'hA700);
    rd_q.push_back(8'hCD);
    rd_q.push_back(8'hAB);
    exp_yaw.push_back(16'hABCD);
    @(negedge clk);
    INT = 1'b1;
    wait_wrt(base + 1);
    INT = 1'b0;
    wait_wrt(base + 2);
    repeat (5) @(negedge clk);
    INT = 1'b1;
    @(negedge clk);
    INT = 1'b0;
    wait_vld(vb + 1);
    repeat (80) @(negedge clk);
    #1;
    checks++;
    if (wrt_cnt != base + 2 || vld_cnt != vb + 1) begin
      errors++;
      $display("FAIL int_in_rdh got=%0d/%0d want=2/1", wrt_cnt - base, vld_cnt - vb);
    end
    test_read(8'h01, 8'h80);
  endtask

  task automatic test_reset_mid();
    int base = wrt_cnt;
    exp_cmd.push_back(16'hA600);
    rd_q.push_back(8'h55);
    @(negedge clk);
    INT = 1'b1;
    wait_wrt(base + 1);
    INT = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (wrt !== 1'b0)        begin errors++; $display("FAIL mid_wrt got=%b want=0", wrt); end
    if (vld !== 1'b0)        begin errors++; $display("FAIL mid_vld got=%b want=0", vld); end
    if (cmd !== 16'h0000)    begin errors++; $display("FAIL mid_cmd got=%h want=0000", cmd); end
    if (yaw_rt !== 16'h0000) begin errors++; $display("FAIL mid_yaw got=%h want=0000", yaw_rt); end
    exp_cmd.delete();
    exp_yaw.delete();
    rd_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    test_config();
    test_read(8'h78, 8'h56);
  endtask

  initial begin
    test_reset();
    test_config();
    test_read(8'h34, 8'h12);
    test_read(8'h00, 8'hFF);
    test_int_during_rdh();
    test_reset_mid();
    checks++;
    if (exp_cmd.size() != 0 || exp_yaw.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d/%0d want=0/0", exp_cmd.size(), exp_yaw.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
